// File: rtl/a4092_pkg.sv
// Shared types and constants for the Zorro III bus-master sequencer.
package a4092_pkg;

  localparam int unsigned LANE_W = 4;
  localparam int unsigned CNT_W  = 8;

  localparam logic [1:0] SIZ_LONG  = 2'b00;
  localparam logic [1:0] SIZ_BYTE  = 2'b01;
  localparam logic [1:0] SIZ_WORD  = 2'b10;
  localparam logic [1:0] SIZ_3BYTE = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA    = 3'd2,
    WAIT    = 3'd3,
    TERM    = 3'd4,
    RECOVER = 3'd5
  } state_t;

  // NCR request captured when the cycle is accepted
  typedef struct packed {
    logic       read;
    logic [1:0] siz;
    logic [1:0] a;
  } ncr_cmd_t;

  // Transfer length in bytes for a 68030 SIZ code
  function automatic logic [2:0] siz_bytes(input logic [1:0] siz);
    case (siz)
      SIZ_BYTE:  return 3'd1;
      SIZ_WORD:  return 3'd2;
      SIZ_3BYTE: return 3'd3;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/z3_lane_decode.sv
// Combinational {siz,a} to byte-lane strobe mask; ds[3] is offset 0, lanes past offset 3 are dropped.
import a4092_pkg::*;

module z3_lane_decode (
  input  logic [1:0]        siz,
  input  logic [1:0]        a,
  output logic [LANE_W-1:0] mask_c
);

  logic [2:0] end_c;

  assign end_c = {1'b0, a} + siz_bytes(siz);

  always_comb begin
    mask_c = '0;
    for (int k = 0; k < LANE_W; k++) begin
      if ((3'(k) >= {1'b0, a}) && (3'(k) < end_c)) mask_c[LANE_W-1-k] = 1'b1;
    end
  end

endmodule

// File: rtl/z3_master_sequencer.sv
// Zorro III bus-master cycle sequencer for NCR 53C710 DMA requests.
// Optional BERR retry is built when Z3_MASTER_RETRY_EN is defined.
import a4092_pkg::*;

module z3_master_sequencer #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned RETRY_LIMIT    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bmaster,
  input  logic              ncr_req,
  input  logic              ncr_read,
  input  logic [1:0]        ncr_siz,
  input  logic [1:0]        ncr_a,
  input  logic              dtack,
  input  logic              berr,
  output logic              fcs,
  output logic              doe,
  output logic [LANE_W-1:0] ds,
  output logic              ncr_sterm,
  output logic              ncr_tea,
  output logic              busy,
  output logic              timeout
);

  state_t                  state_q, state_d;
  ncr_cmd_t                cmd_q;
  logic [CNT_W-1:0]        wait_cnt_q, cnt_inc_c;
  logic [SYNC_STAGES-1:0]  dtack_sync, berr_sync;
  logic                    dtack_s, berr_s;
  logic [LANE_W-1:0]       lane_mask_c;
  logic                    term_ok_c, abort_to_c, retry_c;
  logic                    retry_ok_c, retry_go_q;
  logic                    fcs_d, doe_d, sterm_d, tea_d, busy_d, timeout_d;
  logic [LANE_W-1:0]       ds_d;

  // Target responses are asynchronous to clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dtack_sync <= '0;
      berr_sync  <= '0;
    end else begin
      dtack_sync <= {dtack_sync[SYNC_STAGES-2:0], dtack};
      berr_sync  <= {berr_sync[SYNC_STAGES-2:0], berr};
    end
  end

  assign dtack_s   = dtack_sync[SYNC_STAGES-1];
  assign berr_s    = berr_sync[SYNC_STAGES-1];
  assign cnt_inc_c = wait_cnt_q + CNT_W'(1);

  z3_lane_decode u_lane_decode (
    .siz    (cmd_q.siz),
    .a      (cmd_q.a),
    .mask_c (lane_mask_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; bus loss outranks BERR, BERR outranks DTACK, DTACK outranks timeout
  always_comb begin
    state_d    = state_q;
    term_ok_c  = 1'b0;
    abort_to_c = 1'b0;
    retry_c    = 1'b0;
    case (state_q)
      IDLE:    if (bmaster && ncr_req) state_d = ADDR;
      ADDR:    state_d = bmaster ? DATA : TERM;
      DATA:    state_d = bmaster ? WAIT : TERM;
      WAIT: begin
        if (!bmaster) begin
          state_d = TERM;
        end else if (berr_s) begin
          if (retry_ok_c) begin
            state_d = RECOVER;
            retry_c = 1'b1;
          end else begin
            state_d = TERM;
          end
        end else if (dtack_s) begin
          state_d   = TERM;
          term_ok_c = 1'b1;
        end else if (cnt_inc_c == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d    = TERM;
          abort_to_c = 1'b1;
        end
      end
      TERM:    state_d = RECOVER;
      RECOVER: state_d = retry_go_q ? ADDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values for the state being entered; registered below
  always_comb begin
    fcs_d     = 1'b0;
    doe_d     = 1'b0;
    ds_d      = '0;
    sterm_d   = 1'b0;
    tea_d     = 1'b0;
    busy_d    = (state_d != IDLE);
    timeout_d = timeout | abort_to_c;
    case (state_d)
      ADDR: fcs_d = 1'b1;
      DATA: begin
        fcs_d = 1'b1;
        doe_d = 1'b1;
      end
      WAIT: begin
        fcs_d = 1'b1;
        doe_d = 1'b1;
        ds_d  = lane_mask_c;
      end
      TERM: begin
        sterm_d = term_ok_c;
        tea_d   = ~term_ok_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcs       <= 1'b0;
      doe       <= 1'b0;
      ds        <= '0;
      ncr_sterm <= 1'b0;
      ncr_tea   <= 1'b0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      fcs       <= fcs_d;
      doe       <= doe_d;
      ds        <= ds_d;
      ncr_sterm <= sterm_d;
      ncr_tea   <= tea_d;
      busy      <= busy_d;
      timeout   <= timeout_d;
    end
  end

  // Request capture and WAIT-phase cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q      <= '0;
      wait_cnt_q <= '0;
    end else begin
      if (state_q == IDLE && state_d == ADDR) cmd_q <= {ncr_read, ncr_siz, ncr_a};
      wait_cnt_q <= (state_q == WAIT) ? cnt_inc_c : '0;
    end
  end

  // Direction only steers the external buffers; strobe timing is the same both ways
  logic unused_read;
  assign unused_read = cmd_q.read;

`ifdef Z3_MASTER_RETRY_EN
  logic [CNT_W-1:0] retry_cnt_q;

  assign retry_ok_c = (retry_cnt_q < CNT_W'(RETRY_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_cnt_q <= '0;
      retry_go_q  <= 1'b0;
    end else begin
      if (state_q == IDLE) retry_cnt_q <= '0;
      else if (retry_c)    retry_cnt_q <= retry_cnt_q + CNT_W'(1);
      if (retry_c)                 retry_go_q <= 1'b1;
      else if (state_q == RECOVER) retry_go_q <= 1'b0;
    end
  end
`else
  logic unused_retry;
  assign retry_ok_c   = 1'b0;
  assign retry_go_q   = 1'b0;
  assign unused_retry = retry_c ^ (^CNT_W'(RETRY_LIMIT));
`endif

endmodule
